sequence_generator: RTL

SEQUENCE_GENERATOR -- requirements
Module: sequence_generator

---
 rtl/sequence_pkg.sv | 38 +++
 rtl/sequence_generator.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/sequence_pkg.sv
// Shared definitions for the framed serial sequence generator and the
// five-ones detector used to watch its output stream.
package sequence_pkg;

    localparam int PREAMBLE_LEN_DEF = 5;
    localparam int DATA_W_DEF       = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_GUARD    = 3'd2,
        ST_DATA     = 3'd3,
        ST_STUFF    = 3'd4,
        ST_STOP     = 3'd5
    } seq_state_e;

    localparam int DET_RUN_W = 4;

    typedef struct packed {
        logic                 hit;
        logic [DET_RUN_W-1:0] run;
    } det_step_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Five-ones detector: hit fires on the bit that completes a run of
    // PREAMBLE_LEN_DEF ones; the run saturates so longer runs fire once.
    function automatic det_step_t ones_detect_step(input logic [DET_RUN_W-1:0] run,
                                                   input logic                 b);
        det_step_t r;
        r.run = b ? ((run == '1) ? run : run + 1'b1) : '0;
        r.hit = b && (run == DET_RUN_W'(PREAMBLE_LEN_DEF - 1));
        return r;
    endfunction

endpackage

// File: rtl/sequence_generator.sv
// Frames each accepted word as preamble, guard, MSB-first payload with
// zero-stuffing after long runs of ones, and a stop bit.
module sequence_generator
    import sequence_pkg::*;
#(
    parameter int PREAMBLE_LEN = PREAMBLE_LEN_DEF,
    parameter int DATA_W       = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out,
    output logic              tx_active,
    output logic              frame_done
);

    localparam int CNT_MAX = max_int(PREAMBLE_LEN, DATA_W);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int RUN_W   = max_int($clog2(PREAMBLE_LEN), 1);

    seq_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic [RUN_W-1:0]  run_inc;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              out_q, out_d;
    logic              tx_active_q, tx_active_d;
    logic              frame_done_q, frame_done_d;
    logic              accept;

    assign in_ready = (state_q == ST_IDLE) || (state_q == ST_STOP);
    assign accept   = in_valid && in_ready;

    // State register
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            run_q        <= '0;
            shreg_q      <= '0;
            out_q        <= 1'b0;
            tx_active_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            run_q        <= run_d;
            shreg_q      <= shreg_d;
            out_q        <= out_d;
            tx_active_q  <= tx_active_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next-state logic; cnt_q counts preamble cycles, then payload bits sent
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        run_d   = run_q;
        shreg_d = shreg_q;
        run_inc = run_q + 1'b1;
        case (state_q)
            ST_IDLE, ST_STOP: begin
                run_d = '0;
                cnt_d = '0;
                if (accept) begin
                    state_d = ST_PREAMBLE;
                    shreg_d = in_data;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PREAMBLE: begin
                if (cnt_q == CNT_W'(PREAMBLE_LEN - 1)) begin
                    state_d = ST_GUARD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GUARD: begin
                state_d = ST_DATA;
                cnt_d   = '0;
                run_d   = '0;
            end
            ST_DATA: begin
                shreg_d = shreg_q << 1;
                run_d   = shreg_q[DATA_W-1] ? run_inc : '0;
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    // Stop bit is a zero, so a run ending here needs no stuff bit
                    state_d = ST_STOP;
                    cnt_d   = '0;
                    run_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (shreg_q[DATA_W-1] && (run_inc == RUN_W'(PREAMBLE_LEN - 1))) begin
                        state_d = ST_STUFF;
                        run_d   = '0;
                    end
                end
            end
            ST_STUFF: begin
                state_d = ST_DATA;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                run_d   = '0;
                shreg_d = '0;
            end
        endcase
    end

    // Outputs are decoded from the upcoming state so they register with it
    always_comb begin
        out_d        = 1'b0;
        tx_active_d  = 1'b0;
        frame_done_d = 1'b0;
        case (state_d)
            ST_PREAMBLE: begin
                out_d       = 1'b1;
                tx_active_d = 1'b1;
            end
            ST_GUARD, ST_STUFF: begin
                tx_active_d = 1'b1;
            end
            ST_DATA: begin
                out_d       = shreg_d[DATA_W-1];
                tx_active_d = 1'b1;
            end
            ST_STOP: begin
                tx_active_d  = 1'b1;
                frame_done_d = 1'b1;
            end
            default: begin
                out_d = 1'b0;
            end
        endcase
    end

    assign out        = out_q;
    assign tx_active  = tx_active_q;
    assign frame_done = frame_done_q;

endmodule
